// File: rtl/max_seq_pkg.sv
// Shared types and widths for the max-selection sequencing controller.
package max_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT,
        CAPTURE,
        OUT
    } state_t;

    localparam int MAX_NUM_IN = 8;
    localparam int CNT_W      = $clog2(MAX_NUM_IN + 1);
    localparam int MAX_OP_LAT = 4;
    // Wait counter only ever holds OP_LAT-1.
    localparam int WAIT_W     = $clog2(MAX_OP_LAT);

endpackage

// File: rtl/max_tie_detect.sv
// Counts slots equal to the operation unit result; a tie is any count other than one.
module max_tie_detect
    import max_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 8
) (
    input  logic [NUM_IN*DATA_W-1:0] slots,
    input  logic [DATA_W-1:0]        op_result,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     tie
);

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (slots[i*DATA_W +: DATA_W] == op_result) begin
                match_cnt = match_cnt + CNT_W'(1);
            end
        end
    end

    assign tie = (match_cnt != CNT_W'(1));

endmodule

// File: rtl/max_seq_ctrl.sv
// Frame collector and sequencer for the 8-input unsigned max operation unit:
// fills a slot bank, pulses the unit, samples its result and reports uniqueness.
module max_seq_ctrl
    import max_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 8,
    parameter int OP_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     op_en,
    output logic [NUM_IN*DATA_W-1:0] op_data,
    input  logic [DATA_W-1:0]        op_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_tie
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]   slots [NUM_IN];
    logic [CNT_W-1:0]    match_cnt;
    logic                tie;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_bank
            assign op_data[g*DATA_W +: DATA_W] = slots[g];
        end
    endgenerate

    max_tie_detect #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN)
    ) u_tie (
        .slots     (op_data),
        .op_result (op_result),
        .match_cnt (match_cnt),
        .tie       (tie)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // in_ready is a pure function of state, so in_valid alone qualifies transfers here.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        op_en     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (in_last || NUM_IN == 1) ? FIRE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || cnt == CNT_W'(NUM_IN - 1))) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                op_en     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = OUT;
            OUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wait_cnt  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tie   <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A new frame starts from a clean bank so short frames pad with zero.
                    if (in_valid) begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            slots[i] <= (i == 0) ? in_data : '0;
                        end
                        cnt <= CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            if (CNT_W'(i) == cnt) begin
                                slots[i] <= in_data;
                            end
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIRE: wait_cnt <= WAIT_W'(OP_LAT - 1);
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                CAPTURE: begin
                    res_data  <= op_result;
                    res_tie   <= tie;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == CAPTURE) begin
            assert (match_cnt <= CNT_W'(NUM_IN));
        end
    end

endmodule
